// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver state encoding and counter sizing.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_e;

    // Width of the per-bit clock counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser for the serial line plus a 3-sample history whose
// majority gives a glitch-tolerant bit value.
`timescale 1ns/1ps
module uart_rx_sync_vote (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_sync,
    output logic vote_c
);

    logic [1:0] sync_q, sync_d;
    logic [2:0] hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[0], rx_async};
        hist_d = {hist_q[1:0], sync_q[1]};
    end

    // Idle-high reset so a freshly reset receiver never sees a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rx_sync = sync_q[1];
    assign vote_c  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: framing FSM, data shift register and a
// valid/ready holding register with overrun reporting.
`timescale 1ns/1ps
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_Valid,
    input  logic                 i_Rx_Ready,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_END       = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

    logic rx_sync;
    logic vote_c;

    uart_rx_sync_vote u_sync_vote (
        .clk      (i_Clock),
        .rst_n    (i_Rst_n),
        .rx_async (i_Rx_Serial),
        .rx_sync  (rx_sync),
        .vote_c   (vote_c)
    );

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 zero_q, zero_d;

    logic                 done_c;
    logic                 frame_ferr_c;
    logic                 frame_brk_c;
    logic                 stop_ferr_c;
    logic                 stop_zero_c;
    logic                 par_x_c;

    assign stop_ferr_c = ferr_q | ~vote_c;
    assign stop_zero_c = zero_q & ~vote_c;
    assign par_x_c     = (^shreg_q) ^ vote_c;

    // Frame FSM; every sample after START is one bit period past the previous one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        zero_d       = zero_q;
        done_c       = 1'b0;
        frame_ferr_c = 1'b0;
        frame_brk_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync) begin
                    state_d = ST_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    zero_d  = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = vote_c ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    shreg_d = {vote_c, shreg_q[DATA_BITS-1:1]};
                    zero_d  = stop_zero_c;
                    if (idx_q == IDX_LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY == PAR_ODD) ? ~par_x_c : par_x_c;
                    zero_d  = stop_zero_c;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d  = '0;
                    ferr_d = stop_ferr_c;
                    zero_d = stop_zero_c;
                    if (idx_q == IDX_LAST_STOP) begin
                        idx_d        = '0;
                        done_c       = 1'b1;
                        frame_ferr_c = stop_ferr_c;
                        frame_brk_c  = stop_zero_c;
                        state_d      = stop_zero_c ? ST_BRK_WAIT : ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_BRK_WAIT: begin
                cnt_d = '0;
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            zero_q  <= zero_d;
        end
    end

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 hperr_q, hperr_d;
    logic                 hferr_q, hferr_d;
    logic                 hbrk_q, hbrk_d;
    logic                 ovr_q, ovr_d;
    logic                 load_c;

    // Holding register: a completing frame loads if the slot is free or being drained.
    always_comb begin
        load_c  = done_c & (~valid_q | i_Rx_Ready);
        valid_d = valid_q & ~i_Rx_Ready;
        data_d  = data_q;
        hperr_d = hperr_q;
        hferr_d = hferr_q;
        hbrk_d  = hbrk_q;
        ovr_d   = done_c & valid_q & ~i_Rx_Ready;
        if (load_c) begin
            valid_d = 1'b1;
            data_d  = shreg_q;
            hperr_d = perr_q;
            hferr_d = frame_ferr_c;
            hbrk_d  = frame_brk_c;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            hperr_q <= 1'b0;
            hferr_q <= 1'b0;
            hbrk_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            hperr_q <= hperr_d;
            hferr_q <= hferr_d;
            hbrk_q  <= hbrk_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_Rx_Valid   = valid_q;
    assign o_Rx_Data    = data_q;
    assign o_Parity_Err = hperr_q;
    assign o_Frame_Err  = hferr_q;
    assign o_Break      = hbrk_q;
    assign o_Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance (A) and a 7-bit even-parity,
// two-stop instance (B), both at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rdy_a = 1'b1, rdy_b = 1'b1;
    logic       a_valid, a_perr, a_ferr, a_brk, a_ovr;
    logic       b_valid, b_perr, b_ferr, b_brk, b_ovr;
    logic [7:0] a_data;
    logic [6:0] b_data;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_a), .o_Rx_Valid(a_valid),
        .i_Rx_Ready(rdy_a), .o_Rx_Data(a_data), .o_Parity_Err(a_perr),
        .o_Frame_Err(a_ferr), .o_Break(a_brk), .o_Overrun(a_ovr));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_b), .o_Rx_Valid(b_valid),
        .i_Rx_Ready(rdy_b), .o_Rx_Data(b_data), .o_Parity_Err(b_perr),
        .o_Frame_Err(b_ferr), .o_Break(b_brk), .o_Overrun(b_ovr));

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [8:0] data;
        logic       bad_par;
        logic       bad_stop;
        int         glitch_bit;
        exp_t       exp;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rx_cnt_a = 0, rx_cnt_b = 0, ovr_cnt_a = 0;
    int   exp_cnt_a = 0, exp_cnt_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop and compare each frame as the consumer accepts it.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t act;
            exp_t e;
            if (a_ovr) ovr_cnt_a++;
            if (a_valid && rdy_a) begin
                rx_cnt_a++;
                act = '{data: 9'(a_data), perr: a_perr, ferr: a_ferr, brk: a_brk};
                if (q_a.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame_a unexpected: got 0x%0h expected none", act);
                end else begin
                    e = q_a.pop_front();
                    check("frame_a", 32'(act), 32'(e));
                end
            end
            if (b_valid && rdy_b) begin
                rx_cnt_b++;
                act = '{data: 9'(b_data), perr: b_perr, ferr: b_ferr, brk: b_brk};
                if (q_b.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame_b unexpected: got 0x%0h expected none", act);
                end else begin
                    e = q_b.pop_front();
                    check("frame_b", 32'(act), 32'(e));
                end
            end
        end
    end

    // One bit period on the selected line; optional glitch, forced-low head, ready pulse.
    task automatic drive_bit(input bit sel, input logic v, input int glitch_off,
                             input int lo_cycles, input int rdy_at);
        logic lv;
        for (int c = 0; c < CPB; c++) begin
            @(posedge clk);
            #1;
            lv = v;
            if (c == glitch_off) lv = ~v;
            if (c < lo_cycles) lv = 1'b0;
            if (sel) rx_b = lv;
            else     rx_a = lv;
            if (rdy_at >= 0) rdy_a = (c == rdy_at);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [8:0] data, input logic bad_par,
                              input logic bad_stop, input int glitch_bit, input int rdy_at);
        int   nd;
        int   nstop;
        int   li;
        logic pb;
        nd    = sel ? 7 : 8;
        nstop = sel ? 2 : 1;
        li    = 0;
        drive_bit(sel, 1'b0, (li == glitch_bit) ? 6 : -1, 0, -1);
        li++;
        for (int i = 0; i < nd; i++) begin
            drive_bit(sel, data[i], (li == glitch_bit) ? 6 : -1, 0, -1);
            li++;
        end
        if (sel) begin
            pb = (^data[6:0]) ^ bad_par;
            drive_bit(sel, pb, (li == glitch_bit) ? 6 : -1, 0, -1);
            li++;
        end
        for (int s = 0; s < nstop; s++) begin
            drive_bit(sel, 1'b1, -1, (bad_stop && s == 0) ? 8 : 0,
                      (s == nstop - 1) ? rdy_at : -1);
        end
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit sel, input logic [8:0] d, input logic bp,
                                input logic bs, input int g, input logic [8:0] ed,
                                input logic ep, input logic ef, input logic eb);
        vec_t v;
        v.sel = sel; v.data = d; v.bad_par = bp; v.bad_stop = bs; v.glitch_bit = g;
        v.exp = '{data: ed, perr: ep, ferr: ef, brk: eb};
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        vecs[0]  = mk(0, 9'h0A5, 0, 0, -1, 9'h0A5, 0, 0, 0);
        vecs[1]  = mk(0, 9'h000, 0, 0, -1, 9'h000, 0, 0, 0);
        vecs[2]  = mk(0, 9'h0FF, 0, 0, -1, 9'h0FF, 0, 0, 0);
        vecs[3]  = mk(0, 9'h0A5, 0, 0,  2, 9'h0A5, 0, 0, 0);
        vecs[4]  = mk(0, 9'h0FF, 0, 0,  5, 9'h0FF, 0, 0, 0);
        vecs[5]  = mk(0, 9'h03C, 0, 1, -1, 9'h03C, 0, 1, 0);
        vecs[6]  = mk(1, 9'h041, 1, 0, -1, 9'h041, 1, 0, 0);
        vecs[7]  = mk(1, 9'h041, 0, 0, -1, 9'h041, 0, 0, 0);
        vecs[8]  = mk(1, 9'h07F, 0, 0, -1, 9'h07F, 0, 0, 0);
        vecs[9]  = mk(1, 9'h000, 1, 0, -1, 9'h000, 1, 0, 0);
        vecs[10] = mk(1, 9'h02A, 0, 0,  3, 9'h02A, 0, 0, 0);
        vecs[11] = mk(0, 9'h080, 0, 0, -1, 9'h080, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'({a_valid, a_data, a_perr, a_ferr, a_brk, a_ovr}), 32'h0);
        check("reset_b", 32'({b_valid, b_data, b_perr, b_ferr, b_brk, b_ovr}), 32'h0);
        rst_n = 1'b1;
        idle_bits(2);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].sel) begin q_b.push_back(vecs[i].exp); exp_cnt_b++; end
            else             begin q_a.push_back(vecs[i].exp); exp_cnt_a++; end
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop,
                       vecs[i].glitch_bit, -1);
            idle_bits(2);
            check("count_a", 32'(rx_cnt_a), 32'(exp_cnt_a));
            check("count_b", 32'(rx_cnt_b), 32'(exp_cnt_b));
        end

        // Short low pulse on an idle line must not start a frame.
        rx_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_a = 1'b1;
        idle_bits(3);
        check("idle_glitch_count", 32'(rx_cnt_a), 32'(exp_cnt_a));

        // Break: one frame with break and framing error, then silence until line high.
        q_a.push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
        exp_cnt_a++;
        rx_a = 1'b0;
        idle_bits(20);
        check("break_count_low", 32'(rx_cnt_a), 32'(exp_cnt_a));
        check("break_flags", 32'({a_brk, a_ferr}), 32'h3);
        rx_a = 1'b1;
        idle_bits(3);
        check("break_count_high", 32'(rx_cnt_a), 32'(exp_cnt_a));

        // Overrun: second frame dropped while the first is held.
        rdy_a = 1'b0;
        q_a.push_back('{data: 9'h011, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(0, 9'h011, 0, 0, -1, -1);
        idle_bits(1);
        send_frame(0, 9'h022, 0, 0, -1, -1);
        idle_bits(1);
        check("ovr_valid", 32'(a_valid), 32'h1);
        check("ovr_data", 32'(a_data), 32'h11);
        check("ovr_pulses", 32'(ovr_cnt_a), 32'h1);
        rdy_a = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_accept_valid", 32'(a_valid), 32'h0);
        exp_cnt_a++;
        check("ovr_count", 32'(rx_cnt_a), 32'(exp_cnt_a));

        // Accept on the very edge a new frame completes: reload, no overrun.
        rdy_a = 1'b0;
        q_a.push_back('{data: 9'h033, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(0, 9'h033, 0, 0, -1, -1);
        idle_bits(1);
        check("simul_held", 32'({a_valid, a_data}), 32'h133);
        q_a.push_back('{data: 9'h044, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(0, 9'h044, 0, 0, -1, 10);
        idle_bits(1);
        check("simul_reload", 32'({a_valid, a_data}), 32'h144);
        check("simul_no_ovr", 32'(ovr_cnt_a), 32'h1);
        rdy_a = 1'b1;
        idle_bits(1);
        exp_cnt_a += 2;
        check("simul_count", 32'(rx_cnt_a), 32'(exp_cnt_a));

        // Reset during bit 3 of 0xFF: nothing delivered, outputs cleared.
        drive_bit(0, 1'b0, -1, 0, -1);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, -1, 0, -1);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({a_valid, a_data, a_perr, a_ferr, a_brk, a_ovr}), 32'h0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle_bits(2);
        check("midreset_count", 32'(rx_cnt_a), 32'(exp_cnt_a));
        check("midreset_valid", 32'(a_valid), 32'h0);
        q_a.push_back('{data: 9'h05A, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        exp_cnt_a++;
        send_frame(0, 9'h05A, 0, 0, -1, -1);
        idle_bits(2);
        check("post_reset_count", 32'(rx_cnt_a), 32'(exp_cnt_a));
        check("drain_a", 32'(q_a.size()), 32'h0);
        check("drain_b", 32'(q_b.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver and successor to the fixed 8N1 receiver. It adds the following:
- configurable data width, parity and stop bits;
- 3-sample majority voting;
- error and break reporting;
- a valid/ready output holding register with overrun detection.

It sits between an FPGA pin and any byte-stream consumer, such as a command parser or FIFO, in the same clock domain.

## Interface
- CLKS_PER_BIT, 87, clocks per bit (i_Clock frequency / baud); legal range 8..65535
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- i_Clock  in  1  system clock; all logic on rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Rx_Serial  in  1  asynchronous serial line, idle high
- o_Rx_Valid  out  1  holding register holds an unread frame
- i_Rx_Ready  in  1  consumer accepts the frame when o_Rx_Valid && i_Rx_Ready
- o_Rx_Data  out  DATA_BITS  received data, LSB first on the line
- o_Parity_Err  out  1  parity mismatch for the held frame (0 when PARITY = 0)
- o_Frame_Err  out  1  a stop bit was sampled 0 for the held frame
- o_Break  out  1  held frame was a break (all sampled bits 0)
- o_Overrun  out  1  one-cycle pulse: a completed frame was dropped

## Operation
- **Synchroniser.** Two flops, reset to 1. A 3-bit history of synchronised samples also resets to 3'b111.
- **Bit decision.** Every bit decision is the majority of the 3 most recent synchronised samples, taken at the sample point.
- **State machine.** States are IDLE, START, DATA, PARITY, STOP, BRK_WAIT. Reset state is IDLE.
  - IDLE: on synchronised line = 0, clear the counter and go to START.
  - START: at count (CLKS_PER_BIT-1)/2, take the vote. Vote 0: clear the counter and go to DATA. Vote 1 (glitch): go to IDLE.
  - DATA: at count CLKS_PER_BIT-1, shift the vote into bit index, clear the counter, increment index. After DATA_BITS bits go to PARITY if PARITY != 0, else STOP.
  - PARITY: one bit period. Error if the XOR of data bits and parity bit is 0 for odd, or 1 for even.
  - STOP: STOP_BITS bit periods, each sampled at mid-bit. Frame_Err is set if any stop vote is 0.
  - Exit after the final stop sample: break goes to BRK_WAIT, otherwise IDLE.
  - The early exit (half a bit early) gives resync margin for back-to-back frames.
- **Break.** All data, parity and stop votes are 0. Deliver the frame with o_Break=1 and o_Frame_Err=1, go to BRK_WAIT, and stay there until the synchronised line = 1, then go to IDLE.
- **Holding register.**
  - On frame completion with the register empty, or being accepted in the same cycle: load data and flags, set o_Rx_Valid.
  - Acceptance clears o_Rx_Valid.
  - Completion while full and not accepted: discard the new frame, keep the old one, pulse o_Overrun.
- Counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS+1).
- **Reset mid-frame.** Everything returns to reset values immediately, and no partial frame is delivered.

## Timing
- Reset values:
  - o_Rx_Valid=0, o_Rx_Data=0, o_Parity_Err=0, o_Frame_Err=0, o_Break=0, o_Overrun=0.
  - State IDLE, counters 0.
- Start detection lags the line by 2 synchroniser cycles plus 1 cycle into START.
- o_Rx_Valid, data and flags update on the clock edge that takes the final stop sample; they are visible on the following cycle.
- Data and flags stay stable while o_Rx_Valid=1.
- o_Overrun is high for exactly one cycle, coincident with the dropped frame's completion edge.
- Simultaneous accept and completion: the new frame loads, o_Rx_Valid stays 1, and there is no overrun.
- i_Rx_Ready is ignored while o_Rx_Valid=0.

## Structure
- Shared package uart_pkg holds:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the receiver state encoding;
  - a function computing counter width.
- Sub-module uart_rx_sync_vote: 2-flop synchroniser plus 3-sample history. Outputs the synchronised line and the majority vote.
- Top level holds the FSM, shift register and holding register.

## Test plan
All tests use CLKS_PER_BIT=16.
- **8N1, ready tied 1.** Send 0xA5 → one valid cycle, o_Rx_Data=0xA5, all flags 0.
- **DATA_BITS=7, PARITY=2 (even).** Send 0x41 with parity bit 1 → o_Parity_Err=1; repeat with parity 0 → o_Parity_Err=0.
- **Stop bit 0.** Send 0x3C with stop bit driven 0 → o_Rx_Data=0x3C, o_Frame_Err=1. Hold line 0 for 20 bit times → o_Break=1, no second frame until the line returns high.
- **Overrun.** Ready held 0; send 0x11 then 0x22 → o_Rx_Data stays 0x11 and o_Overrun pulses once. Assert ready → 0x11 accepted, valid drops.
- **Glitch rejection.** A 4-cycle low pulse on idle line → no frame. A single-cycle 1 glitch mid data bit → bit still decoded correctly by the vote.
- **Reset mid-frame.** Assert i_Rst_n=0 during bit 3 of 0xFF, release while line idle → all outputs 0, next frame 0x5A received correctly.
